amp_power_sequencer: RTL and testbench

- Top-level bring-up controller for one Merus Gen1 amplifier channel. It sequences amp power enable, I2C configuration (drives the `send_cfg` trigger of the amp I2C master and waits for its done flag), I2S clock presence, and soft unmute.
- It also handles amp fault recovery with bounded retries and an orderly mute-then-disable shutdown.
- It sits between the user/control register enable bit and the amp frontend (I2C master plus amp pins).

---
 rtl/amp_power_sequencer.sv | 149 ++++++++++++++
 tb/tb_amp_power_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/amp_power_sequencer.sv
// Bring-up/shutdown sequencer for one amp channel: power, I2C config, clock check, unmute, fault retry.
// Outputs registered from the next state; amp_fault_n enters through a 2-FF synchronizer.
module amp_power_sequencer #(
   parameter int CW        = 16,
   parameter int T_PWR     = 1000,
   parameter int T_CFG     = 20000,
   parameter int T_UNMUTE  = 500,
   parameter int T_RECOVER = 5000,
   parameter int MAX_RETRY = 3
) (
   input  logic       clk_in,
   input  logic       resetb,
   input  logic       enable,
   input  logic       cfg_done,
   input  logic       i2s_locked,
   input  logic       amp_fault_n,
   output logic       amp_en,
   output logic       amp_mute_n,
   output logic       send_cfg,
   output logic [3:0] state_o,
   output logic [3:0] retry_cnt,
   output logic       lockout
);

   typedef enum logic [3:0] {
      OFF      = 4'd0,
      PWRUP    = 4'd1,
      CFG_REQ  = 4'd2,
      CFG_WAIT = 4'd3,
      CLK_WAIT = 4'd4,
      UNMUTE   = 4'd5,
      RUN      = 4'd6,
      SHUTDOWN = 4'd7,
      FAULT    = 4'd8,
      LOCKOUT  = 4'd9
   } state_t;

   localparam logic [CW-1:0] LD_PWR = CW'(T_PWR - 1);
   localparam logic [CW-1:0] LD_CFG = CW'(T_CFG - 1);
   localparam logic [CW-1:0] LD_UNM = CW'(T_UNMUTE - 1);
   localparam logic [CW-1:0] LD_REC = CW'(T_RECOVER - 1);
   localparam logic [3:0]    MAX_R  = 4'(MAX_RETRY);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [3:0]    retry_nxt;
   logic          fault_meta, fault_sync, fault;
   logic          expired, active;
   logic          amp_en_nxt, mute_n_nxt, send_cfg_nxt, lockout_nxt;

   always_ff @(posedge clk_in or negedge resetb) begin
      if (!resetb) begin
         fault_meta <= 1'b1;
         fault_sync <= 1'b1;
      end else begin
         fault_meta <= amp_fault_n;
         fault_sync <= fault_meta;
      end
   end

   assign fault   = ~fault_sync;
   assign expired = (cnt == '0);
   assign active  = (state inside {PWRUP, CFG_REQ, CFG_WAIT, CLK_WAIT, UNMUTE, RUN});

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      retry_nxt    = retry_cnt;
      amp_en_nxt   = 1'b0;
      mute_n_nxt   = 1'b0;
      send_cfg_nxt = 1'b0;
      lockout_nxt  = 1'b0;

      case (state)
         OFF:      if (enable) state_nxt = PWRUP;
         PWRUP:    if (expired) state_nxt = CFG_REQ;
         CFG_REQ:  state_nxt = CFG_WAIT;
         CFG_WAIT: begin
            // a done pulse on the expiry cycle still counts as success
            if (cfg_done)     state_nxt = CLK_WAIT;
            else if (expired) state_nxt = FAULT;
         end
         CLK_WAIT: if (i2s_locked) state_nxt = UNMUTE;
         UNMUTE: begin
            if (!i2s_locked)  state_nxt = CLK_WAIT;
            else if (expired) state_nxt = RUN;
         end
         RUN:      if (!i2s_locked) state_nxt = CLK_WAIT;
         SHUTDOWN: if (expired) state_nxt = OFF;
         FAULT: begin
            if (!enable)      state_nxt = OFF;
            else if (expired) state_nxt = (retry_cnt < MAX_R) ? PWRUP : LOCKOUT;
         end
         LOCKOUT:  if (!enable) state_nxt = OFF;
         default:  state_nxt = OFF;
      endcase

      // fault outranks the enable drop and every normal transition
      if (active) begin
         if (fault)        state_nxt = FAULT;
         else if (!enable) state_nxt = SHUTDOWN;
      end

      if (state_nxt != state) begin
         case (state_nxt)
            PWRUP:            cnt_nxt = LD_PWR;
            CFG_WAIT:         cnt_nxt = LD_CFG;
            UNMUTE, SHUTDOWN: cnt_nxt = LD_UNM;
            FAULT:            cnt_nxt = LD_REC;
            default:          cnt_nxt = '0;
         endcase
      end else if (!expired) begin
         cnt_nxt = cnt - 1'b1;
      end

      if (state_nxt == OFF)
         retry_nxt = '0;
      else if (state_nxt == FAULT && state != FAULT && retry_cnt < MAX_R)
         retry_nxt = retry_cnt + 1'b1;

      amp_en_nxt   = (state_nxt inside {PWRUP, CFG_REQ, CFG_WAIT, CLK_WAIT, UNMUTE, RUN, SHUTDOWN});
      mute_n_nxt   = (state_nxt == RUN);
      send_cfg_nxt = (state_nxt == CFG_REQ);
      lockout_nxt  = (state_nxt == LOCKOUT);
   end

   always_ff @(posedge clk_in or negedge resetb) begin
      if (!resetb) begin
         state      <= OFF;
         cnt        <= '0;
         retry_cnt  <= '0;
         amp_en     <= 1'b0;
         amp_mute_n <= 1'b0;
         send_cfg   <= 1'b0;
         lockout    <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         retry_cnt  <= retry_nxt;
         amp_en     <= amp_en_nxt;
         amp_mute_n <= mute_n_nxt;
         send_cfg   <= send_cfg_nxt;
         lockout    <= lockout_nxt;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_amp_power_sequencer.sv
// Directed bench for amp_power_sequencer with short timing parameters.
module tb_amp_power_sequencer;

   logic       clk_in = 1'b0;
   logic       resetb, enable, cfg_done, i2s_locked, amp_fault_n;
   logic       amp_en, amp_mute_n, send_cfg, lockout;
   logic [3:0] state_o, retry_cnt;

   int         tests  = 0;
   int         failed = 0;
   logic [3:0] pulses = 4'd0;
   logic [3:0] consec = 4'd0;
   logic       send_prev = 1'b0;

   amp_power_sequencer #(
      .CW(16), .T_PWR(8), .T_CFG(20), .T_UNMUTE(4), .T_RECOVER(10), .MAX_RETRY(2)
   ) dut (
      .clk_in(clk_in), .resetb(resetb), .enable(enable), .cfg_done(cfg_done),
      .i2s_locked(i2s_locked), .amp_fault_n(amp_fault_n), .amp_en(amp_en),
      .amp_mute_n(amp_mute_n), .send_cfg(send_cfg), .state_o(state_o),
      .retry_cnt(retry_cnt), .lockout(lockout)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) begin
      if (send_cfg) pulses <= pulses + 4'd1;
      if (send_cfg && send_prev) consec <= consec + 4'd1;
      send_prev <= send_cfg;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // from the cycle PWRUP was entered, with i2s_locked high, through to RUN
   task automatic finish_bringup();
      repeat (8) tick();
      tick();
      cfg_done = 1'b1;
      tick();
      cfg_done = 1'b0;
      tick();
      repeat (4) tick();
   endtask

   initial begin
      resetb = 1'b0; enable = 1'b0; cfg_done = 1'b0; i2s_locked = 1'b0; amp_fault_n = 1'b1;
      repeat (3) tick();
      resetb = 1'b1;
      chk4("rst_state", state_o, 4'd0);
      chk1("rst_amp_en", amp_en, 1'b0);
      chk1("rst_mute_n", amp_mute_n, 1'b0);
      chk1("rst_send_cfg", send_cfg, 1'b0);
      chk4("rst_retry", retry_cnt, 4'd0);
      chk1("rst_lockout", lockout, 1'b0);
      tick();
      chk4("off_idle", state_o, 4'd0);

      // nominal bring-up
      i2s_locked = 1'b1; enable = 1'b1;
      tick();
      chk4("nom_pwrup_state", state_o, 4'd1);
      chk1("nom_pwrup_en", amp_en, 1'b1);
      repeat (7) tick();
      chk1("nom_no_cfg_early", send_cfg, 1'b0);
      chk4("nom_still_pwrup", state_o, 4'd1);
      tick();
      chk1("nom_send_cfg", send_cfg, 1'b1);
      chk4("nom_cfg_req", state_o, 4'd2);
      tick();
      chk1("nom_send_cfg_drop", send_cfg, 1'b0);
      chk4("nom_cfg_wait", state_o, 4'd3);
      chk4("nom_pulses", pulses, 4'd1);
      repeat (3) tick();
      cfg_done = 1'b1;
      tick();
      cfg_done = 1'b0;
      chk4("nom_clk_wait", state_o, 4'd4);
      tick();
      chk4("nom_unmute", state_o, 4'd5);
      repeat (3) tick();
      chk1("nom_mute_held", amp_mute_n, 1'b0);
      tick();
      chk1("nom_mute_rise", amp_mute_n, 1'b1);
      chk4("nom_run", state_o, 4'd6);
      chk1("nom_run_en", amp_en, 1'b1);

      // clock loss in RUN
      i2s_locked = 1'b0;
      tick();
      chk4("clk_loss_state", state_o, 4'd4);
      chk1("clk_loss_mute", amp_mute_n, 1'b0);
      tick();
      chk4("clk_loss_hold", state_o, 4'd4);
      i2s_locked = 1'b1;
      tick();
      chk4("clk_back_unmute", state_o, 4'd5);
      repeat (3) tick();
      chk1("clk_back_muted", amp_mute_n, 1'b0);
      tick();
      chk1("clk_back_mute_rise", amp_mute_n, 1'b1);
      chk4("clk_back_run", state_o, 4'd6);
      chk4("clk_back_no_cfg", pulses, 4'd1);

      // orderly shutdown
      enable = 1'b0;
      tick();
      chk4("sd_state", state_o, 4'd7);
      chk1("sd_mute", amp_mute_n, 1'b0);
      chk1("sd_en_held", amp_en, 1'b1);
      repeat (3) tick();
      chk1("sd_en_held_end", amp_en, 1'b1);
      tick();
      chk1("sd_en_off", amp_en, 1'b0);
      chk4("sd_off", state_o, 4'd0);

      // config timeout twice -> lockout
      enable = 1'b1;
      tick();
      repeat (8) tick();
      chk1("to_send_cfg", send_cfg, 1'b1);
      tick();
      repeat (19) tick();
      chk4("to_wait_last", state_o, 4'd3);
      chk1("to_wait_en", amp_en, 1'b1);
      tick();
      chk4("to_fault", state_o, 4'd8);
      chk1("to_fault_en", amp_en, 1'b0);
      chk4("to_retry1", retry_cnt, 4'd1);
      repeat (9) tick();
      chk4("to_fault_hold", state_o, 4'd8);
      chk1("to_fault_en_low", amp_en, 1'b0);
      tick();
      chk4("to_repwrup", state_o, 4'd1);
      chk1("to_repwrup_en", amp_en, 1'b1);
      repeat (8) tick();
      chk1("to_second_cfg", send_cfg, 1'b1);
      tick();
      chk4("to_pulses", pulses, 4'd3);
      repeat (20) tick();
      chk4("to_fault2", state_o, 4'd8);
      chk4("to_retry2", retry_cnt, 4'd2);
      repeat (10) tick();
      chk4("lo_state", state_o, 4'd9);
      chk1("lo_flag", lockout, 1'b1);
      chk1("lo_en", amp_en, 1'b0);
      chk4("lo_retry", retry_cnt, 4'd2);
      repeat (3) tick();
      chk4("lo_hold", state_o, 4'd9);
      enable = 1'b0;
      tick();
      chk4("lo_exit_off", state_o, 4'd0);
      chk4("lo_exit_retry", retry_cnt, 4'd0);
      chk1("lo_exit_flag", lockout, 1'b0);

      // fault in RUN
      enable = 1'b1;
      tick();
      finish_bringup();
      chk4("fr_run", state_o, 4'd6);
      chk4("fr_pulses", pulses, 4'd4);
      amp_fault_n = 1'b0;
      tick();
      chk1("fr_edge1_en", amp_en, 1'b1);
      tick();
      chk1("fr_edge2_en", amp_en, 1'b1);
      tick();
      chk4("fr_edge3_state", state_o, 4'd8);
      chk1("fr_edge3_en", amp_en, 1'b0);
      chk1("fr_edge3_mute", amp_mute_n, 1'b0);
      chk4("fr_retry", retry_cnt, 4'd1);
      amp_fault_n = 1'b1;
      repeat (9) tick();
      chk4("fr_fault_hold", state_o, 4'd8);
      tick();
      chk4("fr_repwrup", state_o, 4'd1);
      finish_bringup();
      chk4("fr_rerun", state_o, 4'd6);
      chk4("fr_rerun_retry", retry_cnt, 4'd1);
      chk1("fr_rerun_mute", amp_mute_n, 1'b1);
      chk4("fr_rerun_pulses", pulses, 4'd5);

      // cfg_done on the timeout expiry cycle
      enable = 1'b0;
      repeat (5) tick();
      chk4("co_off", state_o, 4'd0);
      chk4("co_retry_clr", retry_cnt, 4'd0);
      enable = 1'b1;
      tick();
      repeat (8) tick();
      chk1("co_send_cfg", send_cfg, 1'b1);
      tick();
      repeat (19) tick();
      cfg_done = 1'b1;
      tick();
      cfg_done = 1'b0;
      chk4("co_clk_wait", state_o, 4'd4);
      chk4("co_no_retry", retry_cnt, 4'd0);
      chk1("co_en", amp_en, 1'b1);

      // reset in the middle of CFG_WAIT
      enable = 1'b0;
      repeat (6) tick();
      chk4("rm_off", state_o, 4'd0);
      enable = 1'b1;
      tick();
      repeat (8) tick();
      tick();
      repeat (3) tick();
      chk4("rm_cfg_wait", state_o, 4'd3);
      chk1("rm_en_before", amp_en, 1'b1);
      #2 resetb = 1'b0;
      #1;
      chk4("rm_state", state_o, 4'd0);
      chk1("rm_en", amp_en, 1'b0);
      chk1("rm_mute", amp_mute_n, 1'b0);
      chk1("rm_send_cfg", send_cfg, 1'b0);
      chk1("rm_lockout", lockout, 1'b0);
      enable = 1'b0;
      tick();
      resetb = 1'b1;
      tick();
      chk4("rm_after_off", state_o, 4'd0);
      chk4("send_cfg_consecutive", consec, 4'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
